// File: rtl/gold_nic.sv
// Network interface between one processing element and a router port.
// Holds a single-entry outbound buffer and a single-entry inbound buffer, each with a full flag.
module gold_nic #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di
);

    localparam logic [1:0] ADDR_IBUF = 2'b00;
    localparam logic [1:0] ADDR_ISTS = 2'b01;
    localparam logic [1:0] ADDR_OBUF = 2'b10;
    localparam logic [1:0] ADDR_OSTS = 2'b11;
    localparam int         VC_BIT    = DATA_W - 1;

    logic [DATA_W-1:0] obuf;
    logic [DATA_W-1:0] ibuf;
    logic              ofull;
    logic              ifull;

    logic              rd_en;
    logic              wr_accept;
    logic              rx_accept;
    logic              ibuf_drain;
    logic [DATA_W-1:0] rd_data;

    // A packet only leaves when the router's current polarity matches its virtual channel.
    assign net_so = ~reset & ofull & net_ro & (obuf[VC_BIT] == net_polarity);
    assign net_do = obuf;
    assign net_ri = ~reset & ~ifull;

    assign rd_en      = nicEn & ~nicWrEn;
    assign wr_accept  = nicEn & nicWrEn & (addr == ADDR_OBUF) & ~ofull;
    assign rx_accept  = net_si & net_ri;
    assign ibuf_drain = rd_en & (addr == ADDR_IBUF) & ifull;

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_IBUF: rd_data = ibuf;
            ADDR_ISTS: rd_data = {{(DATA_W-1){1'b0}}, ifull};
            ADDR_OBUF: rd_data = '0;
            ADDR_OSTS: rd_data = {{(DATA_W-1){1'b0}}, ofull};
            default:   rd_data = '0;
        endcase
    end

    // Outbound: a send clears ofull; a write in the send cycle sees ofull=1 and is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            obuf  <= '0;
            ofull <= 1'b0;
        end else if (net_so) begin
            ofull <= 1'b0;
        end else if (wr_accept) begin
            obuf  <= d_in;
            ofull <= 1'b1;
        end
    end

    // Inbound: arrival and drain are exclusive since arrival requires ifull=0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ibuf  <= '0;
            ifull <= 1'b0;
        end else if (rx_accept) begin
            ibuf  <= net_di;
            ifull <= 1'b1;
        end else if (ibuf_drain) begin
            ifull <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out <= '0;
        end else if (rd_en) begin
            d_out <= rd_data;
        end
    end

endmodule
